// File: rtl/rah_result_serializer_if.sv
// Bundle between the result serializer, its result source and the encoder app FIFO.
// fsm_state mirrors the serializer FSM encoding so checkers can observe it.
interface rah_result_serializer_if #(
   parameter int DATA_WIDTH   = 48,
   parameter int RESULT_WIDTH = 256
);
   logic                    in_valid;
   logic                    in_ready;
   logic [RESULT_WIDTH-1:0] in_data;
   logic                    fifo_full;
   logic                    wrdata;
   logic [DATA_WIDTH-1:0]   send_data;
   logic                    busy;
   logic                    done;
   logic [15:0]             frame_cnt;
   logic [1:0]              fsm_state;

   modport slave (
      input  in_valid, in_data, fifo_full,
      output in_ready, wrdata, send_data, busy, done, frame_cnt, fsm_state
   );

   modport master (
      output in_valid, in_data, fifo_full,
      input  in_ready, wrdata, send_data, busy, done, frame_cnt, fsm_state
   );
endinterface

// File: rtl/rah_result_serializer.sv
// Splits one wide result word into framed 48-bit RAH packets for the encoder app FIFO.
// Optional checksum trailer packet is enabled by defining RAH_SER_CKSUM_EN.
module rah_result_serializer #(
   parameter int         DATA_WIDTH   = 48,
   parameter int         RESULT_WIDTH = 256,
   parameter logic [7:0] TAG          = 8'h5A
) (
   input logic                 clk,
   input logic                 rst,
   rah_result_serializer_if.slave bus
);
   // Handshake: a word transfers on a rising edge where in_valid and in_ready are both
   // high; the source holds in_valid/in_data until then. A packet transfers to the FIFO
   // on every rising edge where wrdata is high; wrdata is never raised while fifo_full.
   localparam int         BEATS    = RESULT_WIDTH / 32;
   localparam logic [5:0] LAST_IDX = 6'(BEATS - 1);

`ifdef RAH_SER_CKSUM_EN
   typedef enum logic [1:0] {IDLE = 2'd0, SEND = 2'd1, CKSUM = 2'd2} state_t;
   localparam logic [5:0] TRAILER_IDX = 6'(BEATS);
   logic [31:0] cksum_q;
`else
   typedef enum logic [1:0] {IDLE = 2'd0, SEND = 2'd1} state_t;
`endif

   state_t                  state_q, state_d;
   logic [RESULT_WIDTH-1:0] shift_q;
   logic [5:0]              idx_q;
   logic [15:0]             frame_cnt_q;
   logic                    done_q;
   logic                    in_ready;
   logic                    accept;
   logic                    wr;
   logic                    last_wr;
   logic                    eof;
   logic [31:0]             payload;
   logic [DATA_WIDTH-1:0]   pkt;

   assign payload = shift_q[RESULT_WIDTH-1 -: 32];

`ifdef RAH_SER_CKSUM_EN
   assign eof = 1'b0;
`else
   assign eof = (idx_q == LAST_IDX);
`endif

   always_comb begin
      state_d  = state_q;
      in_ready = 1'b0;
      accept   = 1'b0;
      wr       = 1'b0;
      last_wr  = 1'b0;
      pkt      = '0;
      case (state_q)
         IDLE: begin
            in_ready = ~rst;
            accept   = bus.in_valid & ~rst;
            if (accept) state_d = SEND;
         end
         SEND: begin
            wr  = ~bus.fifo_full;
            pkt = {TAG, (idx_q == 6'd0), eof, idx_q, payload};
            if (wr && idx_q == LAST_IDX) begin
`ifdef RAH_SER_CKSUM_EN
               state_d = CKSUM;
`else
               state_d = IDLE;
               last_wr = 1'b1;
`endif
            end
         end
`ifdef RAH_SER_CKSUM_EN
         CKSUM: begin
            wr  = ~bus.fifo_full;
            pkt = {TAG, 1'b0, 1'b1, TRAILER_IDX, cksum_q};
            if (wr) begin
               state_d = IDLE;
               last_wr = 1'b1;
            end
         end
`endif
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q     <= IDLE;
         shift_q     <= '0;
         idx_q       <= '0;
         frame_cnt_q <= '0;
         done_q      <= 1'b0;
`ifdef RAH_SER_CKSUM_EN
         cksum_q     <= '0;
`endif
      end else begin
         state_q <= state_d;
         done_q  <= last_wr;
         if (last_wr) frame_cnt_q <= frame_cnt_q + 16'd1;
         if (accept) begin
            shift_q <= bus.in_data;
            idx_q   <= '0;
`ifdef RAH_SER_CKSUM_EN
            cksum_q <= '0;
`endif
         end else if (wr && state_q == SEND) begin
            // Next beat always sits in the top 32 bits of the shift register.
            shift_q <= shift_q << 32;
            idx_q   <= idx_q + 6'd1;
`ifdef RAH_SER_CKSUM_EN
            cksum_q <= cksum_q ^ payload;
`endif
         end
      end
   end

   assign bus.in_ready  = in_ready;
   assign bus.wrdata    = wr;
   assign bus.send_data = pkt;
   assign bus.busy      = (state_q != IDLE);
   assign bus.done      = done_q;
   assign bus.frame_cnt = frame_cnt_q;
   assign bus.fsm_state = state_q;
endmodule

// File: tb/tb_rah_result_serializer.sv
// Bench for rah_result_serializer: directed framing/stall/reset steps plus random frames
// under random FIFO back-pressure, checked against a packet-list model of the framing rules.
module tb_rah_result_serializer;
  localparam int DW    = 48;
  localparam int RW    = 256;
  localparam int BEATS = RW / 32;
`ifdef RAH_SER_CKSUM_EN
  localparam int NPK = BEATS + 1;
`else
  localparam int NPK = BEATS;
`endif

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   cyc = 0;
  int   total = 0;
  int   bad = 0;
  int   frames_exp = 0;
  int   chk_w = 0;
  int   chk_s = 0;
  logic full_dir = 1'b0;
  logic rand_full = 1'b0;
  logic rand_bit = 1'b0;

  logic [DW-1:0] exp_q[$];
  logic [DW-1:0] wr_dat_q[$];
  int            wr_cyc_q[$];
  int            stall_pos_q[$];
  logic [DW-1:0] stall_dat_q[$];
  int            done_cyc_q[$];

  rah_result_serializer_if #(.DATA_WIDTH(DW), .RESULT_WIDTH(RW)) bus ();
  assign bus.fifo_full = rand_full ? rand_bit : full_dir;

  rah_result_serializer #(.DATA_WIDTH(DW), .RESULT_WIDTH(RW), .TAG(8'h5A)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  // clock / reset block
  always #5 clk = ~clk;
  always @(posedge clk) cyc = cyc + 1;
  always @(posedge clk) begin
    #1;
    rand_bit = ($urandom_range(0, 3) == 0);
  end

  // observation log, sampled mid-cycle
  always @(negedge clk) begin
    if (!rst) begin
      if (bus.wrdata) begin
        wr_cyc_q.push_back(cyc);
        wr_dat_q.push_back(bus.send_data);
      end else if (bus.busy) begin
        stall_pos_q.push_back(wr_dat_q.size());
        stall_dat_q.push_back(bus.send_data);
      end
      if (bus.done) done_cyc_q.push_back(cyc);
    end
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // reference model: the packet list one result word must produce
  function automatic void push_frame(input logic [RW-1:0] w);
    logic [31:0] p;
    logic [31:0] x;
    logic [7:0]  hdr;
    x = '0;
    for (int i = 0; i < BEATS; i++) begin
      p   = 32'(w >> (RW - 32 - 32 * i));
      x   = x ^ p;
      hdr = 8'(i);
      if (i == 0) hdr[7] = 1'b1;
`ifndef RAH_SER_CKSUM_EN
      if (i == BEATS - 1) hdr[6] = 1'b1;
`endif
      exp_q.push_back({8'h5A, hdr, p});
    end
`ifdef RAH_SER_CKSUM_EN
    exp_q.push_back({8'h5A, 8'h40 | 8'(BEATS), x});
`endif
  endfunction

  // driver tasks
  task automatic send_word(input logic [RW-1:0] w, output int c);
    bus.in_valid = 1'b1;
    bus.in_data  = w;
    c = -1;
    for (int k = 0; k < 300; k++) begin
      @(negedge clk);
      if (bus.in_ready) begin
        c = cyc;
        break;
      end
      @(posedge clk);
      #1;
    end
    check("accept_seen", 64'(c >= 0), 64'(1));
    if (c >= 0) begin
      push_frame(w);
      frames_exp++;
    end
    @(posedge clk);
    #1;
  endtask

  task automatic wait_done(input int c0, output int rel);
    rel = -1;
    for (int k = 0; k < 800; k++) begin
      @(negedge clk);
      if (bus.done) begin
        rel = cyc - c0;
        break;
      end
    end
    check("done_seen", 64'(rel >= 0), 64'(1));
    if (rel >= 0) begin
      check("frame_cnt", 64'(bus.frame_cnt), 64'(16'(frames_exp)));
      check("ready_at_done", 64'(bus.in_ready), 64'(1));
      @(negedge clk);
      check("done_one_cycle", 64'(bus.done), 64'(0));
    end
    @(posedge clk);
    #1;
  endtask

  // scoreboard: every written packet and every stalled packet against the model list
  task automatic score();
    for (int i = chk_w; i < wr_dat_q.size(); i++)
      check("pkt", 64'(wr_dat_q[i]), (i < exp_q.size()) ? 64'(exp_q[i]) : 64'hx);
    chk_w = wr_dat_q.size();
    check("pkt_count", 64'(wr_dat_q.size()), 64'(exp_q.size()));
    for (int i = chk_s; i < stall_dat_q.size(); i++)
      check("stall_hold", 64'(stall_dat_q[i]),
            (stall_pos_q[i] < exp_q.size()) ? 64'(exp_q[stall_pos_q[i]]) : 64'hx);
    chk_s = stall_dat_q.size();
  endtask

  initial begin : stim
    logic [RW-1:0] w;
    logic [RW-1:0] vec;
    logic [DW-1:0] pk;
    int c0, c1, rel, base, base_d;

    vec = 256'h11111111_22222222_33333333_44444444_55555555_66666666_77777777_88888888;
    bus.in_valid = 1'b0;
    bus.in_data  = '0;

    // reset values
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_wrdata", 64'(bus.wrdata), 64'(0));
    check("rst_send_data", 64'(bus.send_data), 64'(0));
    check("rst_in_ready", 64'(bus.in_ready), 64'(0));
    check("rst_frame_cnt", 64'(bus.frame_cnt), 64'(0));
    check("rst_done", 64'(bus.done), 64'(0));
    check("rst_busy", 64'(bus.busy), 64'(0));
    @(posedge clk);
    #1 rst = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check("idle_send_data", 64'(bus.send_data), 64'(0));

    // unstalled frame timing and packet contents
    base = wr_dat_q.size();
    send_word(vec, c0);
    bus.in_valid = 1'b0;
    check("t2_busy", 64'(bus.busy), 64'(1));
    check("t2_ready_busy", 64'(bus.in_ready), 64'(0));
    wait_done(c0, rel);
    check("t2_done_cycle", 64'(rel), 64'(NPK + 1));
    check("t2_nwrites", 64'(wr_dat_q.size() - base), 64'(NPK));
    check("t2_first_cycle", 64'(wr_cyc_q[base] - c0), 64'(1));
    check("t2_last_cycle", 64'(wr_cyc_q[base + NPK - 1] - c0), 64'(NPK));
    check("t2_beat0", 64'(wr_dat_q[base]), 64'(48'h5A80_11111111));
    check("t2_beat3", 64'(wr_dat_q[base + 3]), 64'(48'h5A03_44444444));
`ifdef RAH_SER_CKSUM_EN
    check("t2_beat7", 64'(wr_dat_q[base + 7]), 64'(48'h5A07_88888888));
    check("t2_trailer", 64'(wr_dat_q[base + 8]), 64'(48'h5A48_88888888));
`else
    check("t2_beat7", 64'(wr_dat_q[base + 7]), 64'(48'h5A47_88888888));
`endif
    score();

    // fifo_full on cycles 3..5 of the frame
    base = wr_dat_q.size();
    send_word(vec, c0);
    bus.in_valid = 1'b0;
    @(posedge clk);
    #1;
    @(posedge clk);
    #1 full_dir = 1'b1;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      check("t3_stall_wrdata", 64'(bus.wrdata), 64'(0));
      check("t3_stall_data", 64'(bus.send_data), 64'(48'h5A02_33333333));
      @(posedge clk);
      #1;
    end
    full_dir = 1'b0;
    wait_done(c0, rel);
    check("t3_done_cycle", 64'(rel), 64'(NPK + 4));
    check("t3_beat2_cycle", 64'(wr_cyc_q[base + 2] - c0), 64'(6));
    check("t3_nwrites", 64'(wr_dat_q.size() - base), 64'(NPK));
    score();

    // in_valid held across two words
    base = wr_dat_q.size();
    send_word(vec, c0);
    w = ~vec;
    send_word(w, c1);
    bus.in_valid = 1'b0;
    check("t4_second_accept", 64'(c1 - c0), 64'(NPK + 1));
    wait_done(c1, rel);
    check("t4_done2_cycle", 64'(rel + c1 - c0), 64'(2 * (NPK + 1)));
    check("t4_frame2_beat0_cycle", 64'(wr_cyc_q[base + NPK] - c0), 64'(NPK + 2));
    score();

    // reset once beat 3 has been written
    base   = wr_dat_q.size();
    base_d = done_cyc_q.size();
    send_word(vec, c0);
    bus.in_valid = 1'b0;
    repeat (4) @(posedge clk);
    #1 rst = 1'b1;
    @(negedge clk);
    check("t5_rst_wrdata", 64'(bus.wrdata), 64'(0));
    check("t5_rst_send_data", 64'(bus.send_data), 64'(0));
    check("t5_rst_in_ready", 64'(bus.in_ready), 64'(0));
    check("t5_rst_done", 64'(bus.done), 64'(0));
    check("t5_rst_frame_cnt", 64'(bus.frame_cnt), 64'(0));
    check("t5_rst_fsm_idle", 64'(bus.busy), 64'(0));
    frames_exp = 0;
    while (exp_q.size() > wr_dat_q.size()) void'(exp_q.pop_back());
    @(posedge clk);
    #1 rst = 1'b0;
    repeat (12) @(posedge clk);
    #1;
    check("t5_writes_total", 64'(wr_dat_q.size() - base), 64'(4));
    check("t5_no_done", 64'(done_cyc_q.size() - base_d), 64'(0));
    check("t5_frame_cnt", 64'(bus.frame_cnt), 64'(0));
    w = {$urandom(), $urandom(), $urandom(), $urandom(), $urandom(), $urandom(), $urandom(), $urandom()};
    send_word(w, c0);
    bus.in_valid = 1'b0;
    wait_done(c0, rel);
    pk = wr_dat_q[base + 4];
    check("t5_restart_hdr", 64'(pk[47:32]), 64'(16'h5A80));
    score();

    // random words under random back-pressure
    rand_full = 1'b1;
    for (int f = 0; f < 16; f++) begin
      for (int j = 0; j < BEATS; j++) w = {w[RW-33:0], $urandom()};
      repeat ($urandom_range(0, 3)) @(posedge clk);
      #1;
      send_word(w, c0);
      bus.in_valid = 1'b0;
      wait_done(c0, rel);
      score();
    end
    rand_full = 1'b0;
    repeat (4) @(posedge clk);
    #1;
    check("final_busy", 64'(bus.busy), 64'(0));
    check("final_frame_cnt", 64'(bus.frame_cnt), 64'(16'(frames_exp)));
    score();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
